// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter sharing one cache-line data memory between
// the instruction cache (port 0) and the data cache (port 1).
module dmem_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              p0_req_i,
   input  logic              p0_write_i,
   input  logic [ADDR_W-1:0] p0_addr_i,
   input  logic [DATA_W-1:0] p0_data_i,
   output logic [DATA_W-1:0] p0_data_o,
   output logic              p0_ack_o,
   input  logic              p1_req_i,
   input  logic              p1_write_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [DATA_W-1:0] p1_data_i,
   output logic [DATA_W-1:0] p1_data_o,
   output logic              p1_ack_o,
   output logic [1:0]        grant_o,
   input  logic [DATA_W-1:0] mem_data_i,
   input  logic              mem_ack_i,
   output logic [DATA_W-1:0] mem_data_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic              mem_enable_o,
   output logic              mem_write_o
);

   typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

   state_t state, state_nxt;
   logic   prio;
   logic   pick0, pick1;

   // Ties go to the port named by prio; a lone requester always wins.
   assign pick0 = p0_req_i & (~p1_req_i | ~prio);
   assign pick1 = p1_req_i & (~p0_req_i |  prio);

   always_ff @(posedge clk_i) begin
      if (!rst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pick0 | pick1) state_nxt = BUSY;
         BUSY:    if (mem_ack_i)     state_nxt = RELEASE;
         RELEASE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // grant_o is only nonzero in BUSY, so acks cannot leak in IDLE/RELEASE.
   always_comb begin
      p0_ack_o  = mem_ack_i & grant_o[0];
      p1_ack_o  = mem_ack_i & grant_o[1];
      p0_data_o = mem_data_i;
      p1_data_o = mem_data_i;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         grant_o      <= '0;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         prio         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick0) begin
                  grant_o      <= 2'b01;
                  mem_enable_o <= 1'b1;
                  mem_write_o  <= p0_write_i;
                  mem_addr_o   <= p0_addr_i;
                  mem_data_o   <= p0_data_i;
                  prio         <= 1'b1;
               end else if (pick1) begin
                  grant_o      <= 2'b10;
                  mem_enable_o <= 1'b1;
                  mem_write_o  <= p1_write_i;
                  mem_addr_o   <= p1_addr_i;
                  mem_data_o   <= p1_data_i;
                  prio         <= 1'b0;
               end
            end
            BUSY: begin
               if (mem_ack_i) begin
                  grant_o      <= '0;
                  mem_enable_o <= 1'b0;
                  mem_write_o  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: expected grants are queued when requests
// are driven and compared when the arbiter presents them to memory.
module tb_dmem_arbiter;

   logic         clk_i = 1'b0;
   logic         rst_i;
   logic         p0_req_i, p0_write_i, p1_req_i, p1_write_i;
   logic [31:0]  p0_addr_i, p1_addr_i, mem_addr_o;
   logic [255:0] p0_data_i, p1_data_i, p0_data_o, p1_data_o;
   logic [255:0] mem_data_i, mem_data_o;
   logic         p0_ack_o, p1_ack_o, mem_ack_i, mem_enable_o, mem_write_o;
   logic [1:0]   grant_o;

   typedef struct {
      logic [1:0]   grant;
      logic         write;
      logic [31:0]  addr;
      logic [255:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(256)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .p0_req_i(p0_req_i), .p0_write_i(p0_write_i), .p0_addr_i(p0_addr_i),
      .p0_data_i(p0_data_i), .p0_data_o(p0_data_o), .p0_ack_o(p0_ack_o),
      .p1_req_i(p1_req_i), .p1_write_i(p1_write_i), .p1_addr_i(p1_addr_i),
      .p1_data_i(p1_data_i), .p1_data_o(p1_data_o), .p1_ack_o(p1_ack_o),
      .grant_o(grant_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
      .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
      .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_grant(output int waited);
      waited = 0;
      while (waited < 20) begin
         @(negedge clk_i);
         waited++;
         if (mem_enable_o === 1'b1) return;
      end
      check("grant_timeout", 256'(mem_enable_o), 256'(1));
   endtask

   task automatic check_grant(output logic [1:0] g);
      exp_t e;
      if (sb.size() == 0) begin
         check("sb_underflow", 256'(sb.size()), 256'(1));
         g = 2'b00;
      end else begin
         e = sb.pop_front();
         check("grant",     256'(grant_o),     256'(e.grant));
         check("mem_addr",  256'(mem_addr_o),  256'(e.addr));
         check("mem_write", 256'(mem_write_o), 256'(e.write));
         check("mem_data",  mem_data_o,        e.data);
         g = e.grant;
      end
   endtask

   task automatic complete(input int lat, input logic [255:0] rd, input logic [1:0] port);
      repeat (lat) @(negedge clk_i);
      check("busy_enable", 256'(mem_enable_o), 256'(1));
      mem_data_i = rd;
      mem_ack_i  = 1'b1;
      #1;
      check("ack", 256'({p1_ack_o, p0_ack_o}), 256'(port));
      check("rdata", port[0] ? p0_data_o : p1_data_o, rd);
      @(negedge clk_i);
      mem_ack_i  = 1'b0;
      mem_data_i = ~rd;
      #1;
      check("ack_pulse",    256'({p1_ack_o, p0_ack_o}), 256'(0));
      check("post_enable",  256'(mem_enable_o), 256'(0));
      check("post_write",   256'(mem_write_o),  256'(0));
      check("post_grant",   256'(grant_o),      256'(0));
   endtask

   initial begin
      int           w;
      logic [1:0]   g;
      logic [255:0] data0, data1, wdat, a5;
      data0 = {8{32'hDEADBEEF}};
      data1 = {8{32'h5555AAAA}};
      wdat  = {4{64'h0123456789ABCDEF}};
      a5    = {32{8'hA5}};

      rst_i = 1'b0; mem_ack_i = 1'b0; mem_data_i = '0;
      p0_req_i = 1'b1; p0_write_i = 1'b0; p0_addr_i = 32'h0000_0400; p0_data_i = data0;
      p1_req_i = 1'b0; p1_write_i = 1'b0; p1_addr_i = 32'h0000_0800; p1_data_i = data1;

      // reset held with p0 requesting
      repeat (3) begin
         @(negedge clk_i);
         check("rst_grant",  256'(grant_o),      256'(0));
         check("rst_enable", 256'(mem_enable_o), 256'(0));
         check("rst_write",  256'(mem_write_o),  256'(0));
         check("rst_addr",   256'(mem_addr_o),   256'(0));
         check("rst_data",   mem_data_o,         256'(0));
         check("rst_acks",   256'({p1_ack_o, p0_ack_o}), 256'(0));
      end
      sb.push_back('{grant: 2'b01, write: 1'b0, addr: 32'h400, data: data0});
      rst_i = 1'b1;
      wait_grant(w);
      check("grant_latency", 256'(w), 256'(1));
      check_grant(g);
      complete(10, a5, 2'b01);
      p0_req_i = 1'b0;

      // both ports from reset: p0, p1, p0, p1
      rst_i = 1'b0;
      @(negedge clk_i);
      p0_req_i = 1'b1; p1_req_i = 1'b1;
      rst_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (i % 2 == 0) sb.push_back('{grant: 2'b01, write: 1'b0, addr: 32'h400, data: data0});
         else            sb.push_back('{grant: 2'b10, write: 1'b0, addr: 32'h800, data: data1});
      end
      for (int i = 0; i < 4; i++) begin
         wait_grant(w);
         if (i > 0) check("gap_ge2", 256'(w >= 2), 256'(1));
         check_grant(g);
         complete(3, {8{32'hC0DE0000 | 32'(i)}}, g);
      end
      p0_req_i = 1'b0; p1_req_i = 1'b0;

      // p1 write; inputs change during BUSY
      p1_write_i = 1'b1; p1_addr_i = 32'h0000_0020; p1_data_i = wdat; p1_req_i = 1'b1;
      sb.push_back('{grant: 2'b10, write: 1'b1, addr: 32'h20, data: wdat});
      wait_grant(w);
      check_grant(g);
      p1_addr_i = 32'hFFFF_FFE0; p1_data_i = ~wdat; p1_write_i = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         check("hold_addr",  256'(mem_addr_o),  256'(32'h20));
         check("hold_data",  mem_data_o,        wdat);
         check("hold_write", 256'(mem_write_o), 256'(1));
      end
      complete(2, data1, 2'b10);
      p1_req_i = 1'b0;

      // spurious ack in IDLE
      @(negedge clk_i);
      mem_ack_i = 1'b1;
      #1;
      check("spur_acks",  256'({p1_ack_o, p0_ack_o}), 256'(0));
      check("spur_grant", 256'(grant_o), 256'(0));
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      check("spur_enable", 256'(mem_enable_o), 256'(0));
      check("spur_grant2", 256'(grant_o),      256'(0));

      // p0 drops req mid-BUSY
      p0_addr_i = 32'h0000_1000; p0_req_i = 1'b1;
      sb.push_back('{grant: 2'b01, write: 1'b0, addr: 32'h1000, data: data0});
      wait_grant(w);
      check_grant(g);
      @(negedge clk_i);
      p0_req_i = 1'b0;
      repeat (2) @(negedge clk_i);
      check("drop_grant", 256'(grant_o), 256'(1));
      complete(1, a5, 2'b01);

      // reset during a p1 transaction
      @(negedge clk_i);
      p1_addr_i = 32'h0000_2000; p1_req_i = 1'b1;
      sb.push_back('{grant: 2'b10, write: 1'b0, addr: 32'h2000, data: ~wdat});
      wait_grant(w);
      check_grant(g);
      @(negedge clk_i);
      rst_i = 1'b0; p1_req_i = 1'b0;
      @(negedge clk_i);
      check("mid_rst_grant",  256'(grant_o),      256'(0));
      check("mid_rst_enable", 256'(mem_enable_o), 256'(0));
      rst_i = 1'b1;
      mem_ack_i = 1'b1;
      #1;
      check("late_ack", 256'({p1_ack_o, p0_ack_o}), 256'(0));
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      check("late_enable", 256'(mem_enable_o), 256'(0));
      check("late_grant",  256'(grant_o),      256'(0));

      check("sb_empty", 256'(sb.size()), 256'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
